// File: rtl/vx_fetch_sched_pkg.sv
// Shared types, default sizing and helpers for the warp fetch scheduler.
package vx_fetch_sched_pkg;

   localparam int DEF_NUM_WARPS   = 4;
   localparam int DEF_ISSUE_WIDTH = 1;
   localparam int DEF_IBUF_DEPTH  = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   function automatic int credit_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int CREDIT_W = credit_width(DEF_IBUF_DEPTH);

   // Issue widths are powers of two, so the modulo is a plain mask of the low bits.
   function automatic int slot_of(input int wid, input int issue_width);
      return wid % issue_width;
   endfunction

endpackage

// File: rtl/vx_fetch_sched_if.sv
// Scheduler <-> fetch unit handshake: schedule offer, fetch response and ibuf pops.
interface vx_fetch_sched_if
   import vx_fetch_sched_pkg::*;
#(
   parameter int NUM_WARPS   = DEF_NUM_WARPS,
   parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH
);
   localparam int NW_WIDTH = $clog2(NUM_WARPS);

   logic                   sched_valid;
   logic [NW_WIDTH-1:0]    sched_wid;
   logic                   sched_ready;
   logic                   rsp_valid;
   logic [NW_WIDTH-1:0]    rsp_wid;
   logic [ISSUE_WIDTH-1:0] ibuf_pop;

   modport master (
      output sched_valid, sched_wid,
      input  sched_ready, rsp_valid, rsp_wid, ibuf_pop
   );

   modport slave (
      input  sched_valid, sched_wid,
      output sched_ready, rsp_valid, rsp_wid, ibuf_pop
   );
endinterface

// File: rtl/vx_fetch_sched_chk.sv
// Protocol checker: ibuf pop into a full credit pool, response for a non-pending warp.
module vx_fetch_sched_chk
   import vx_fetch_sched_pkg::*;
#(
   parameter int NUM_WARPS   = DEF_NUM_WARPS,
   parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
   parameter int IBUF_DEPTH  = DEF_IBUF_DEPTH,
   parameter int NW_WIDTH    = $clog2(NUM_WARPS),
   localparam int CNT_W      = credit_width(IBUF_DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         en,
   input  logic [ISSUE_WIDTH-1:0]       ibuf_pop,
   input  logic [ISSUE_WIDTH*CNT_W-1:0] credit_cnt,
   input  logic                         rsp_valid,
   input  logic [NW_WIDTH-1:0]          rsp_wid,
   input  logic [NUM_WARPS-1:0]         pending,
   output logic                         pop_full_err,
   output logic                         rsp_err
);

   // Flag the two protocol violations as they are presented.
   always_comb begin
      pop_full_err = 1'b0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
         pop_full_err = pop_full_err |
            (ibuf_pop[s] & (credit_cnt[s*CNT_W +: CNT_W] == CNT_W'(IBUF_DEPTH)));
      end
      rsp_err = rsp_valid & ~pending[rsp_wid];
   end

   // Sample the flags on the edge at which the scheduler would consume them.
   always @(posedge clk) begin
      if (reset_n && en) begin
         a_pop_full: assert (!pop_full_err);
         a_rsp_idle: assert (!rsp_err);
      end
   end

endmodule

// File: rtl/vx_rr_picker.sv
// Combinational round-robin find-first: lowest index at or after ptr, wrapping.
module vx_rr_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid,
   output logic [W-1:0] idx
);

   // Scan from the farthest candidate back towards ptr so the nearest hit wins.
   always_comb begin
      idx   = '0;
      valid = |req;
      for (int i = N - 1; i >= 0; i--) begin
         idx = req[ptr + W'(i)] ? (ptr + W'(i)) : idx;
      end
   end

endmodule

// File: rtl/vx_fetch_sched.sv
// Warp fetch scheduler: round-robin pick of eligible warps under per-slot ibuf credits,
// at most one outstanding fetch per warp, zero-bubble back-to-back offers.
module vx_fetch_sched
   import vx_fetch_sched_pkg::*;
#(
   parameter int NUM_WARPS   = DEF_NUM_WARPS,
   parameter int ISSUE_WIDTH = DEF_ISSUE_WIDTH,
   parameter int IBUF_DEPTH  = DEF_IBUF_DEPTH,
   parameter int NW_WIDTH    = $clog2(NUM_WARPS),
   localparam int CNT_W      = credit_width(IBUF_DEPTH)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_WARPS-1:0]         warp_active,
   input  logic [NUM_WARPS-1:0]         warp_stall,
   vx_fetch_sched_if.master             fif,
   output logic [ISSUE_WIDTH*CNT_W-1:0] credit_cnt,
   output logic                         busy
);

   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(IBUF_DEPTH);

   state_e                 state_r;
   state_e                 state_nxt_s;
   logic                   valid_r;
   logic                   valid_nxt_s;
   logic [NW_WIDTH-1:0]    wid_r;
   logic [NW_WIDTH-1:0]    wid_nxt_s;
   logic [NW_WIDTH-1:0]    rr_ptr_r;
   logic [NW_WIDTH-1:0]    ptr_eff_s;
   logic [NUM_WARPS-1:0]   pending_r;
   logic [NUM_WARPS-1:0]   pending_nxt_s;
   logic [NUM_WARPS-1:0]   pend_eff_s;
   logic [NUM_WARPS-1:0]   accept_oh_s;
   logic [NUM_WARPS-1:0]   rsp_oh_s;
   logic [NUM_WARPS-1:0]   elig_s;
   logic [ISSUE_WIDTH-1:0] acc_s;
   logic [CNT_W-1:0]       credit_r     [ISSUE_WIDTH];
   logic [CNT_W-1:0]       credit_eff_s [ISSUE_WIDTH];
   logic [CNT_W-1:0]       credit_nxt_s [ISSUE_WIDTH];
   logic [CNT_W:0]         sum_s        [ISSUE_WIDTH];
   logic                   hs_s;
   logic                   pick_valid_s;
   logic [NW_WIDTH-1:0]    pick_idx_s;

   assign hs_s            = valid_r & fif.sched_ready;
   assign fif.sched_valid = valid_r;
   assign fif.sched_wid   = wid_r;
   assign busy            = (|pending_r) | valid_r;

   // One-hot views of this cycle's accept and response.
   always_comb begin
      accept_oh_s            = '0;
      rsp_oh_s               = '0;
      accept_oh_s[wid_r]     = hs_s;
      rsp_oh_s[fif.rsp_wid]  = fif.rsp_valid;
      acc_s                  = '0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
         acc_s[s] = hs_s & (slot_of(int'(wid_r), ISSUE_WIDTH) == s);
      end
   end

   // Credit after this cycle's accept (used for the same-cycle pick) and after pops.
   always_comb begin
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
         credit_eff_s[s] = credit_r[s] - CNT_W'(acc_s[s]);
         sum_s[s]        = {1'b0, credit_eff_s[s]} + (CNT_W+1)'(fif.ibuf_pop[s]);
         credit_nxt_s[s] = (sum_s[s] > {1'b0, CREDIT_MAX}) ? CREDIT_MAX : sum_s[s][CNT_W-1:0];
      end
   end

   // Response clears before accept sets, so a coincident pair leaves the warp pending.
   always_comb begin
      pending_nxt_s = (pending_r & ~rsp_oh_s) | accept_oh_s;
      pend_eff_s    = pending_r | accept_oh_s;
      ptr_eff_s     = hs_s ? (wid_r + NW_WIDTH'(1)) : rr_ptr_r;
      elig_s        = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         elig_s[w] = warp_active[w] & ~warp_stall[w] & ~pend_eff_s[w] &
                     (credit_eff_s[slot_of(w, ISSUE_WIDTH)] != '0);
      end
   end

   vx_rr_picker #(
      .N (NUM_WARPS),
      .W (NW_WIDTH)
   ) u_picker (
      .req   (elig_s),
      .ptr   (ptr_eff_s),
      .valid (pick_valid_s),
      .idx   (pick_idx_s)
   );

   // Offer FSM: an offer is held until accepted, then immediately replaced if possible.
   always_comb begin
      state_nxt_s = state_r;
      valid_nxt_s = valid_r;
      wid_nxt_s   = wid_r;
      case (state_r)
         IDLE: begin
            if (pick_valid_s) begin
               state_nxt_s = OFFER;
               valid_nxt_s = 1'b1;
               wid_nxt_s   = pick_idx_s;
            end else begin
               state_nxt_s = IDLE;
               valid_nxt_s = 1'b0;
            end
         end
         OFFER: begin
            if (hs_s && pick_valid_s) begin
               state_nxt_s = OFFER;
               valid_nxt_s = 1'b1;
               wid_nxt_s   = pick_idx_s;
            end else if (hs_s) begin
               state_nxt_s = IDLE;
               valid_nxt_s = 1'b0;
            end else begin
               state_nxt_s = OFFER;
               valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            wid_nxt_s   = '0;
         end
      endcase
   end

   // State, offer, pending, round-robin pointer and credit registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         valid_r   <= 1'b0;
         wid_r     <= '0;
         rr_ptr_r  <= '0;
         pending_r <= '0;
         for (int s = 0; s < ISSUE_WIDTH; s++) begin
            credit_r[s] <= CREDIT_MAX;
         end
      end else begin
         state_r   <= state_nxt_s;
         valid_r   <= valid_nxt_s;
         wid_r     <= wid_nxt_s;
         rr_ptr_r  <= ptr_eff_s;
         pending_r <= pending_nxt_s;
         for (int s = 0; s < ISSUE_WIDTH; s++) begin
            credit_r[s] <= credit_nxt_s[s];
         end
      end
   end

   // Flatten the credit registers onto the debug port.
   always_comb begin
      credit_cnt = '0;
      for (int s = 0; s < ISSUE_WIDTH; s++) begin
         credit_cnt[s*CNT_W +: CNT_W] = credit_r[s];
      end
   end

endmodule

// File: tb/tb_vx_fetch_sched.sv
// Directed bench for vx_fetch_sched with NUM_WARPS=4, ISSUE_WIDTH=1, IBUF_DEPTH=4.
module tb_vx_fetch_sched;
   import vx_fetch_sched_pkg::*;

   localparam int NW    = 4;
   localparam int IW    = 1;
   localparam int DEPTH = 4;

   logic                   clk;
   logic                   reset_n;
   logic                   chk_en;
   logic [NW-1:0]          warp_active;
   logic [NW-1:0]          warp_stall;
   logic [IW*CREDIT_W-1:0] credit_cnt;
   logic                   busy;
   logic [NW-1:0]          pend_view;
   logic                   pop_full_err;
   logic                   rsp_err;

   int total = 0;
   int bad   = 0;

   vx_fetch_sched_if #(.NUM_WARPS(NW), .ISSUE_WIDTH(IW)) fif ();

   vx_fetch_sched #(
      .NUM_WARPS   (NW),
      .ISSUE_WIDTH (IW),
      .IBUF_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .warp_active (warp_active),
      .warp_stall  (warp_stall),
      .fif         (fif.master),
      .credit_cnt  (credit_cnt),
      .busy        (busy)
   );

   assign pend_view = dut.pending_r;

   vx_fetch_sched_chk #(
      .NUM_WARPS   (NW),
      .ISSUE_WIDTH (IW),
      .IBUF_DEPTH  (DEPTH)
   ) chk (
      .clk          (clk),
      .reset_n      (reset_n),
      .en           (chk_en),
      .ibuf_pop     (fif.ibuf_pop),
      .credit_cnt   (credit_cnt),
      .rsp_valid    (fif.rsp_valid),
      .rsp_wid      (fif.rsp_wid),
      .pending      (pend_view),
      .pop_full_err (pop_full_err),
      .rsp_err      (rsp_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   int fair_wid [4] = '{3, 1, 3, 1};
   int prev_wid;

   initial begin
      reset_n         = 1'b1;
      chk_en          = 1'b1;
      warp_active     = 4'b0000;
      warp_stall      = 4'b0000;
      fif.sched_ready = 1'b0;
      fif.rsp_valid   = 1'b0;
      fif.rsp_wid     = 2'd0;
      fif.ibuf_pop    = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_valid",  32'(fif.sched_valid), 32'd0);
      check("rst_wid",    32'(fif.sched_wid),   32'd0);
      check("rst_busy",   32'(busy),            32'd0);
      check("rst_credit", 32'(credit_cnt),      32'd4);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check("idle_no_active", 32'(fif.sched_valid), 32'd0);

      // Back-to-back offers 0,1,2,3 until credit runs out.
      warp_active     = 4'b1111;
      fif.sched_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("b2b_valid", 32'(fif.sched_valid), 32'd1);
         check("b2b_wid",   32'(fif.sched_wid),   32'(i));
      end
      tick();
      check("drain_valid",   32'(fif.sched_valid), 32'd0);
      check("drain_credit",  32'(credit_cnt),      32'd0);
      check("drain_pending", 32'(pend_view),       32'hf);
      check("drain_busy",    32'(busy),            32'd1);

      // Response and pop for warp 2 together: credit 1, offer of warp 2 one cycle later.
      fif.sched_ready = 1'b0;
      fif.rsp_valid   = 1'b1;
      fif.rsp_wid     = 2'd2;
      fif.ibuf_pop    = 1'b1;
      tick();
      fif.rsp_valid   = 1'b0;
      fif.ibuf_pop    = 1'b0;
      check("pop_credit", 32'(credit_cnt),      32'd1);
      check("pop_valid",  32'(fif.sched_valid), 32'd0);
      tick();
      check("w2_valid", 32'(fif.sched_valid), 32'd1);
      check("w2_wid",   32'(fif.sched_wid),   32'd2);

      // Offer held for five cycles without ready; stall raised mid-offer.
      for (int i = 0; i < 5; i++) begin
         if (i == 2) warp_stall = 4'b0100;
         tick();
         check("hold_valid", 32'(fif.sched_valid), 32'd1);
         check("hold_wid",   32'(fif.sched_wid),   32'd2);
      end
      fif.sched_ready = 1'b1;
      tick();
      warp_stall      = 4'b0000;
      fif.sched_ready = 1'b0;
      check("hold_acc_valid",   32'(fif.sched_valid), 32'd0);
      check("hold_acc_pending", 32'(pend_view),       32'hf);
      check("hold_acc_credit",  32'(credit_cnt),      32'd0);

      // Return warps 0 and 1 with pops; warp 0 is offered from rr_ptr=3 with wrap.
      fif.rsp_valid = 1'b1;
      fif.rsp_wid   = 2'd0;
      fif.ibuf_pop  = 1'b1;
      tick();
      check("ret0_credit", 32'(credit_cnt), 32'd1);
      fif.rsp_wid = 2'd1;
      tick();
      fif.rsp_valid = 1'b0;
      check("ret1_credit", 32'(credit_cnt),      32'd2);
      check("ret1_valid",  32'(fif.sched_valid), 32'd1);
      check("ret1_wid",    32'(fif.sched_wid),   32'd0);

      // Accept and pop in the same cycle at credit 2: credit unchanged, warp 1 offered.
      fif.sched_ready = 1'b1;
      tick();
      fif.sched_ready = 1'b0;
      check("accpop_credit",  32'(credit_cnt),    32'd2);
      check("accpop_wid",     32'(fif.sched_wid), 32'd1);
      check("accpop_pending", 32'(pend_view),     32'hd);

      // Pop up to the limit, then once more to hit saturation.
      tick();
      check("sat3", 32'(credit_cnt), 32'd3);
      tick();
      check("sat4", 32'(credit_cnt), 32'd4);
      chk_en = 1'b0;
      check("sat_flag", 32'(pop_full_err), 32'd1);
      tick();
      check("sat_hold", 32'(credit_cnt), 32'd4);
      fif.ibuf_pop = 1'b0;
      chk_en       = 1'b1;

      // Only warps 1 and 3 active; clear outstanding 3, 0, 2 while warp 1 is still offered.
      warp_active   = 4'b1010;
      fif.rsp_valid = 1'b1;
      fif.rsp_wid   = 2'd3;
      tick();
      fif.rsp_wid = 2'd0;
      tick();
      fif.rsp_wid = 2'd2;
      tick();
      fif.rsp_valid = 1'b0;
      check("fair_pre_pending", 32'(pend_view),       32'h0);
      check("fair_pre_wid",     32'(fif.sched_wid),   32'd1);

      // Grants alternate 3,1,3,1; each accepted warp is returned the next cycle.
      fif.sched_ready = 1'b1;
      prev_wid        = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("fair_valid", 32'(fif.sched_valid), 32'd1);
         check("fair_wid",   32'(fif.sched_wid),   32'(fair_wid[k]));
         fif.rsp_valid = 1'b1;
         fif.rsp_wid   = 2'(prev_wid);
         fif.ibuf_pop  = 1'b1;
         tick();
         fif.rsp_valid = 1'b0;
         fif.ibuf_pop  = 1'b0;
         check("fair_gap",    32'(fif.sched_valid), 32'd0);
         check("fair_rr_ptr", 32'(dut.rr_ptr_r),    32'((fair_wid[k] + 1) % 4));
         prev_wid = fair_wid[k];
      end
      check("fair_credit", 32'(credit_cnt), 32'd3);

      // Asynchronous reset while an offer is up and warp 1 is pending.
      fif.sched_ready = 1'b0;
      tick();
      check("pre_rst_valid",   32'(fif.sched_valid), 32'd1);
      check("pre_rst_wid",     32'(fif.sched_wid),   32'd3);
      check("pre_rst_pending", 32'(pend_view),       32'h2);
      #2 reset_n = 1'b0;
      #1;
      check("arst_valid",   32'(fif.sched_valid), 32'd0);
      check("arst_pending", 32'(pend_view),       32'h0);
      check("arst_credit",  32'(credit_cnt),      32'd4);
      check("arst_busy",    32'(busy),            32'd0);

      // Response for an idle warp is flagged.
      chk_en        = 1'b0;
      fif.rsp_valid = 1'b1;
      fif.rsp_wid   = 2'd0;
      #1;
      check("rsp_idle_flag", 32'(rsp_err), 32'd1);
      fif.rsp_valid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
